// File: rtl/mlp_argmax_if.sv
// Host-side bundle for the argmax unit: start/busy control, score vector in,
// winning index/score out over a valid/ready handshake.
interface mlp_argmax_if #(
  parameter int unsigned N_CLASSES = 10,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned IDX_W     = 8
);
  logic              start;
  logic              busy;
  logic [DATA_W-1:0] scores [N_CLASSES];
  logic [IDX_W-1:0]  result;
  logic [DATA_W-1:0] max_score;
  logic              result_valid;
  logic              result_ready;

  modport master (
    output start, scores, result_ready,
    input  busy, result, max_score, result_valid
  );

  modport slave (
    input  start, scores, result_ready,
    output busy, result, max_score, result_valid
  );
endinterface

// File: rtl/mlp_argmax.sv
// Argmax over the MLP output scores: settle delay, one-edge snapshot, then a
// one-compare-per-cycle scan; the winner is returned over valid/ready.
module mlp_argmax #(
  parameter int unsigned N_CLASSES     = 10,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned IDX_W         = 8,
  parameter int unsigned SETTLE_CYCLES = 3,
  parameter bit          SIGNED        = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  mlp_argmax_if.slave bus
);

  localparam int unsigned CNT_W  = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam int unsigned SCAN_W = $clog2(N_CLASSES);
  localparam logic [SCAN_W-1:0] LAST_IDX    = SCAN_W'(N_CLASSES - 1);
  localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_SNAP,
    S_SCAN,
    S_HOLD
  } state_e;

  // With no settle delay an accepted start goes straight to the snapshot.
  localparam state_e START_ST = (SETTLE_CYCLES == 0) ? S_SNAP : S_SETTLE;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SCAN_W-1:0] idx_q, idx_d;
  logic [SCAN_W-1:0] best_idx_q, best_idx_d;
  logic [DATA_W-1:0] best_q, best_d;
  logic [DATA_W-1:0] snap_q [N_CLASSES];
  logic [DATA_W-1:0] snap_d [N_CLASSES];
  logic [IDX_W-1:0]  result_q, result_d;
  logic [DATA_W-1:0] max_q, max_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;

  logic [DATA_W-1:0] cand;
  logic              cand_wins;

  // Strictly-greater compare keeps the lowest index on ties.
  always_comb begin
    cand = snap_q[idx_q];
    if (SIGNED) cand_wins = $signed(cand) > $signed(best_q);
    else        cand_wins = cand > best_q;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    best_idx_d = best_idx_q;
    best_d     = best_q;
    snap_d     = snap_q;
    result_d   = result_q;
    max_d      = max_q;
    valid_d    = valid_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = START_ST;
          cnt_d   = SETTLE_LOAD;
        end
      end
      S_SETTLE: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_SNAP;
      end
      S_SNAP: begin
        snap_d     = bus.scores;
        best_d     = bus.scores[0];
        best_idx_d = '0;
        idx_d      = SCAN_W'(1);
        state_d    = S_SCAN;
      end
      S_SCAN: begin
        if (cand_wins) begin
          best_d     = cand;
          best_idx_d = idx_q;
        end
        idx_d = idx_q + SCAN_W'(1);
        if (idx_q == LAST_IDX) begin
          result_d = IDX_W'(best_idx_d);
          max_d    = best_d;
          valid_d  = 1'b1;
          state_d  = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.result_ready) begin
          valid_d = 1'b0;
          if (bus.start) begin
            state_d = START_ST;
            cnt_d   = SETTLE_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_SETTLE) || (state_d == S_SNAP) || (state_d == S_SCAN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      best_idx_q <= '0;
      best_q     <= '0;
      for (int i = 0; i < N_CLASSES; i++) snap_q[i] <= '0;
      result_q   <= '0;
      max_q      <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      best_idx_q <= best_idx_d;
      best_q     <= best_d;
      for (int i = 0; i < N_CLASSES; i++) snap_q[i] <= snap_d[i];
      result_q   <= result_d;
      max_q      <= max_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.busy         = busy_q;
  assign bus.result       = result_q;
  assign bus.max_score    = max_q;
  assign bus.result_valid = valid_q;

endmodule
